// File: rtl/seq_booth_divider.sv
// Iterative WIDTH/WIDTH integer divider: restoring division on operand magnitudes,
// one quotient bit per cycle, with sign fix-up and valid/ready request/response handshakes.
module seq_booth_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             signed_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

    // Two's-complement negation modulo 2^WIDTH; MIN maps onto itself.
    function automatic logic [WIDTH-1:0] neg2(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             sgn_op_r;
    logic             sign_q_r;
    logic             sign_r_r;
    logic             zero_r;
    logic             ovf_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH:0]   p_r;
    logic [CNT_W-1:0] cnt_r;

    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_r;
    logic             ovf_out_r;

    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   diff_s;

    // One restoring step: shift the next dividend bit in, then trial-subtract.
    always_comb begin
        rem_sh_s = (p_r << 1) | {{WIDTH{1'b0}}, q_r[WIDTH-1]};
        diff_s   = rem_sh_s - {1'b0, d_r};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; ITER runs a fixed WIDTH cycles regardless of operands.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = PREP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PREP: state_nxt_s = ITER;
            ITER: begin
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = FIX;
                end else begin
                    state_nxt_s = ITER;
                end
            end
            FIX:  state_nxt_s = DONE;
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand capture, magnitude preparation and the shift/subtract datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            sgn_op_r <= 1'b0;
            sign_q_r <= 1'b0;
            sign_r_r <= 1'b0;
            zero_r   <= 1'b0;
            ovf_r    <= 1'b0;
            q_r      <= {WIDTH{1'b0}};
            d_r      <= {WIDTH{1'b0}};
            p_r      <= {(WIDTH+1){1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r      <= dividend;
                        b_r      <= divisor;
                        sgn_op_r <= signed_op;
                    end
                end
                PREP: begin
                    sign_q_r <= sgn_op_r & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                    sign_r_r <= sgn_op_r & a_r[WIDTH-1];
                    q_r      <= (sgn_op_r & a_r[WIDTH-1]) ? neg2(a_r) : a_r;
                    d_r      <= (sgn_op_r & b_r[WIDTH-1]) ? neg2(b_r) : b_r;
                    zero_r   <= (b_r == ZERO_VAL);
                    ovf_r    <= sgn_op_r & (a_r == MIN_VAL) & (b_r == ONES_VAL);
                    p_r      <= {(WIDTH+1){1'b0}};
                    cnt_r    <= CNT_INIT;
                end
                ITER: begin
                    // A clear sign bit on the trial difference means the divisor fits.
                    if (!diff_s[WIDTH]) begin
                        p_r <= diff_s;
                        q_r <= {q_r[WIDTH-2:0], 1'b1};
                    end else begin
                        p_r <= rem_sh_s;
                        q_r <= {q_r[WIDTH-2:0], 1'b0};
                    end
                    cnt_r <= cnt_r - CNT_ONE;
                end
                FIX:  cnt_r <= {CNT_W{1'b0}};
                DONE: cnt_r <= {CNT_W{1'b0}};
                default: cnt_r <= {CNT_W{1'b0}};
            endcase
        end
    end

    // Result registers and handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            dbz_r       <= 1'b0;
            ovf_out_r   <= 1'b0;
        end else begin
            in_ready_r <= (state_nxt_s == IDLE);
            case (state_r)
                FIX: begin
                    out_valid_r <= 1'b1;
                    if (zero_r) begin
                        quotient_r  <= ONES_VAL;
                        remainder_r <= a_r;
                        dbz_r       <= 1'b1;
                        ovf_out_r   <= 1'b0;
                    end else if (ovf_r) begin
                        quotient_r  <= MIN_VAL;
                        remainder_r <= ZERO_VAL;
                        dbz_r       <= 1'b0;
                        ovf_out_r   <= 1'b1;
                    end else begin
                        quotient_r  <= sign_q_r ? neg2(q_r) : q_r;
                        remainder_r <= sign_r_r ? neg2(p_r[WIDTH-1:0]) : p_r[WIDTH-1:0];
                        dbz_r       <= 1'b0;
                        ovf_out_r   <= 1'b0;
                    end
                end
                DONE: begin
                    // Values are retained after the handshake; only valid and flags drop.
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        dbz_r       <= 1'b0;
                        ovf_out_r   <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;
    assign overflow    = ovf_out_r;

endmodule
